// File: rtl/pll_seq_pkg.sv
// Shared types and elaboration helpers for the PLL lock reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    CORE_UP,
    RUN
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter only ever holds load values of (interval - 1), so clog2 of
  // the largest interval is wide enough; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: these are ordinary flops, not a memory array, so clearing them on
  // reset is cheap and gives a defined "not locked" value out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Sequences core and peripheral resets from a qualified, synchronized PLL lock,
// re-asserting both on lock loss and keeping a debug loss counter.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int HOLD_CYCLES    = 8,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  clear_loss,
  output logic                  rst_core_n,
  output logic                  rst_periph_n,
  output logic                  ready,
  output logic                  loss_sticky,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_MAX = max3(STABLE_CYCLES, STAGGER_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

  logic                  lock_s;
  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  loss_evt;
  logic                  rst_core_n_q, rst_periph_n_q, ready_q;
  logic                  loss_sticky_q, loss_sticky_d;
  logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clock),
    .rst_n(reset_n),
    .d_i  (pll_locked),
    .q_o  (lock_s)
  );

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;

    case (state_q)
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = STABLE_LOAD;
        end
      end

      // Any low sample restarts qualification from scratch.
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = CORE_UP;
          cnt_d   = STAGGER_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      CORE_UP: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
          state_d  = HOLD;
          cnt_d    = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
          state_d  = HOLD;
          cnt_d    = HOLD_LOAD;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
    endcase
  end

  // A loss in the same cycle as a clear is applied after the clear, so it wins.
  always_comb begin
    loss_sticky_d = loss_sticky_q;
    loss_count_d  = loss_count_q;

    if (clear_loss) begin
      loss_sticky_d = 1'b0;
      loss_count_d  = '0;
    end

    if (loss_evt) begin
      loss_sticky_d = 1'b1;
      if (loss_count_d != {LOSS_CNT_W{1'b1}}) begin
        loss_count_d = loss_count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the next state so they change on the edge entering it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_core_n_q   <= 1'b0;
      rst_periph_n_q <= 1'b0;
      ready_q        <= 1'b0;
      loss_sticky_q  <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      rst_core_n_q   <= (state_d == CORE_UP) || (state_d == RUN);
      rst_periph_n_q <= (state_d == RUN);
      ready_q        <= (state_d == RUN);
      loss_sticky_q  <= loss_sticky_d;
      loss_count_q   <= loss_count_d;
    end
  end

  assign rst_core_n   = rst_core_n_q;
  assign rst_periph_n = rst_periph_n_q;
  assign ready        = ready_q;
  assign loss_sticky  = loss_sticky_q;
  assign loss_count   = loss_count_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: two instances (default and short intervals)
// compared every cycle against a lock-streak model, plus literal timing pins.
module tb_pll_lock_reset_seq;

  localparam int A_SYNC = 2;
  localparam int A_S    = 1024;
  localparam int A_T    = 16;
  localparam int A_H    = 8;
  localparam int B_SYNC = 3;
  localparam int B_S    = 4;
  localparam int B_T    = 3;
  localparam int B_H    = 5;
  localparam int W      = 8;

  logic clock = 1'b0;
  logic reset_n;
  logic pll_a, pll_b, clr_a, clr_b;
  logic core_a, periph_a, ready_a, sticky_a;
  logic core_b, periph_b, ready_b, sticky_b;
  logic [W-1:0] cnt_a, cnt_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model: outputs follow from how many consecutive qualifying lock samples
  // have been seen since the resets were last forced low.
  typedef struct packed {
    bit [7:0] pipe;
    int       blocked;
    int       streak;
    int       losses;
    int       count;
    bit       sticky;
  } model_t;

  model_t ma, mb;

  always #5 clock = ~clock;

  pll_lock_reset_seq u_dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_a),
    .clear_loss  (clr_a),
    .rst_core_n  (core_a),
    .rst_periph_n(periph_a),
    .ready       (ready_a),
    .loss_sticky (sticky_a),
    .loss_count  (cnt_a)
  );

  pll_lock_reset_seq #(
    .SYNC_STAGES   (B_SYNC),
    .STABLE_CYCLES (B_S),
    .STAGGER_CYCLES(B_T),
    .HOLD_CYCLES   (B_H),
    .LOSS_CNT_W    (W)
  ) u_dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_b),
    .clear_loss  (clr_b),
    .rst_core_n  (core_b),
    .rst_periph_n(periph_b),
    .ready       (ready_b),
    .loss_sticky (sticky_b),
    .loss_count  (cnt_b)
  );

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    m.blocked = 1;
    return m;
  endfunction

  function automatic model_t step(model_t m, bit pll, bit clr, int sync, int s, int t, int h);
    bit ls, loss;
    ls   = m.pipe[sync-1];
    loss = 1'b0;
    if (m.blocked > 0) begin
      m.blocked--;
      m.streak = 0;
    end else if (ls) begin
      if (m.streak < s + t + 1) m.streak++;
    end else begin
      loss     = (m.streak >= s + 1);
      m.streak = 0;
      if (loss) m.blocked = h;
    end
    if (clr) begin
      m.count  = 0;
      m.sticky = 1'b0;
    end
    if (loss) begin
      m.sticky = 1'b1;
      m.losses++;
      if (m.count < (1 << W) - 1) m.count++;
    end
    m.pipe = {m.pipe[6:0], pll};
    return m;
  endfunction

  function automatic logic [W+3:0] model_out(model_t m, int s, int t);
    logic core, periph;
    core   = (m.streak >= s + 1);
    periph = (m.streak >= s + t + 1);
    return {core, periph, periph, m.sticky, W'(m.count)};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= step(ma, pll_a, clr_a, A_SYNC, A_S, A_T, A_H);
      mb <= step(mb, pll_b, clr_b, B_SYNC, B_S, B_T, B_H);
    end
  end

  initial begin
    logic [W+3:0] got, exp;
    forever begin
      @(negedge clock);
      got = {core_a, periph_a, ready_a, sticky_a, cnt_a};
      exp = model_out(ma, A_S, A_T);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL cycle_a t=%0t got=%h expected=%h", $time, got, exp);
      end
      got = {core_b, periph_b, ready_b, sticky_b, cnt_b};
      exp = model_out(mb, B_S, B_T);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL cycle_b t=%0t got=%h expected=%h", $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return core_a;
      1:       return periph_a;
      2:       return core_b;
      default: return periph_b;
    endcase
  endfunction

  // Edges until the selected output reaches level; budget on timeout.
  task automatic measure(input int which, input logic level, input int budget, output int n);
    n = 0;
    while (sig(which) !== level && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_b_run(input string name);
    int g;
    g = 0;
    while (mb.streak < B_S + B_T + 1 && g < 200) begin
      tick();
      g++;
    end
    check(name, int'(g < 200), 1);
  endtask

  initial begin
    #700000;
    miscompares++;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int n, k, guard;
    reset_n = 1'b0;
    pll_a   = 1'b1;
    pll_b   = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    tick(3);
    check("reset_core", core_a, 0);
    check("reset_periph", periph_a, 0);
    check("reset_ready", ready_a, 0);
    check("reset_count", cnt_a, 0);

    // Steady lock through reset release: sync 2 + stable 1024 + 1.
    reset_n = 1'b1;
    measure(0, 1'b1, 1100, n);
    check("core_release_latency", n, 1027);
    measure(1, 1'b1, 40, n);
    check("periph_stagger", n, 16);
    check("ready_after_release", ready_a, 1);
    check("count_after_release", cnt_a, 0);

    // Lock loss in RUN.
    pll_a = 1'b0;
    measure(0, 1'b0, 10, n);
    check("run_loss_latency", n, 3);
    check("run_loss_ready", ready_a, 0);
    check("run_loss_sticky", sticky_a, 1);
    check("run_loss_count", cnt_a, 1);
    pll_a = 1'b1;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clear_count", cnt_a, 0);
    check("clear_sticky", sticky_a, 0);

    // One-cycle glitch 500 cycles into qualification restarts the interval.
    tick(507);
    check("glitch_pre_core", core_a, 0);
    pll_a = 1'b0;
    tick();
    pll_a = 1'b1;
    measure(0, 1'b1, 1100, n);
    check("glitch_restart_latency", n, 1027);
    check("glitch_sticky", sticky_a, 0);
    measure(1, 1'b1, 40, n);
    check("glitch_periph_stagger", n, 16);

    // Loss in RUN, lock back at once: 8 hold + 1 + 1024 before core returns.
    pll_a = 1'b0;
    measure(0, 1'b0, 10, n);
    check("run_loss2_latency", n, 3);
    pll_a = 1'b1;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    measure(0, 1'b1, 1100, n);
    check("relock_after_hold", n, 1032);

    // Loss detected on the 5th stagger cycle.
    tick(2);
    pll_a = 1'b0;
    tick(3);
    check("coreup_loss_core", core_a, 0);
    check("coreup_loss_periph", periph_a, 0);
    check("coreup_loss_count", cnt_a, 1);
    check("coreup_loss_sticky", sticky_a, 1);
    tick(30);
    check("coreup_periph_stays_low", periph_a, 0);

    // 300 loss events on the short instance with random timing.
    pll_b = 1'b1;
    guard = 0;
    while (mb.losses < 300 && guard < 20000) begin
      while (mb.streak < B_S + 1 && guard < 20000) begin
        tick();
        guard++;
      end
      k = $urandom_range(0, 6);
      tick(k);
      pll_b = 1'b0;
      k = $urandom_range(1, 3);
      tick(k);
      pll_b = 1'b1;
      if (k < B_SYNC + 1) tick(B_SYNC + 1 - k);
      guard += 10;
    end
    check("saturate_loop_bound", int'(guard < 20000), 1);
    check("loss_count_saturated", cnt_b, 255);
    check("loss_sticky_saturated", sticky_b, 1);
    tick(2);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    check("clear_after_saturate_count", cnt_b, 0);
    check("clear_after_saturate_sticky", sticky_b, 0);

    // Clear coinciding with a loss: loss wins.
    wait_b_run("wait_run_b1");
    pll_b = 1'b0;
    tick(B_SYNC + 1);
    pll_b = 1'b1;
    check("pre_coincide_count", cnt_b, 1);
    wait_b_run("wait_run_b2");
    pll_b = 1'b0;
    tick(B_SYNC);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    pll_b = 1'b1;
    check("coincide_count", cnt_b, 1);
    check("coincide_sticky", sticky_b, 1);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    wait_b_run("wait_run_b3");
    reset_n = 1'b0;
    #1;
    check("async_core", core_b, 0);
    check("async_periph", periph_b, 0);
    check("async_ready", ready_b, 0);
    check("async_sticky", sticky_b, 0);
    check("async_count", cnt_b, 0);
    tick(2);
    reset_n = 1'b1;
    tick();
    check("post_reset_count", cnt_b, 0);

    // Random lock and clear activity on both instances.
    pll_a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) pll_b = ~pll_b;
      if ($urandom_range(0, 1499) == 0) pll_a = ~pll_a;
      clr_b = ($urandom_range(0, 49) == 0);
      clr_a = ($urandom_range(0, 199) == 0);
      tick();
    end
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
